tlb_refill: RTL and testbench

- Owns the 8-entry TLB tag/valid array and the miss-refill state machine.
- Consumes the lookup stage's tlb_miss and per-way hits, issues a page-table-walk request on a miss, and writes the returned translation's tag into a victim way.
- Feeds tags_0..tags_7 and valid back to the lookup stage.
- Victim selection: lowest-indexed invalid way, otherwise 8-way tree pseudo-LRU.

---
 rtl/tlb_refill.sv | 169 ++++++++++++++++
 tb/tb_tlb_refill.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill.sv
// rtl/tlb_refill.sv - 8-entry TLB tag/valid array with miss-refill FSM and tree pseudo-LRU
module tlb_refill #(
  parameter int NWAYS = 8,
  parameter int TAG_W = 34
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [26:0]       io_req_bits_vpn,
  input  logic [6:0]        io_ptw_ptbr_asid,
  input  logic              tlb_miss,
  input  logic [7:0]        hits,
  output logic              io_ptw_req_valid,
  input  logic              io_ptw_req_ready,
  output logic [26:0]       io_ptw_req_bits_addr,
  input  logic              io_ptw_resp_valid,
  input  logic              io_ptw_resp_bits_error,
  input  logic              io_ptw_invalidate,
  output logic [TAG_W-1:0]  tags_0,
  output logic [TAG_W-1:0]  tags_1,
  output logic [TAG_W-1:0]  tags_2,
  output logic [TAG_W-1:0]  tags_3,
  output logic [TAG_W-1:0]  tags_4,
  output logic [TAG_W-1:0]  tags_5,
  output logic [TAG_W-1:0]  tags_6,
  output logic [TAG_W-1:0]  tags_7,
  output logic [7:0]        valid,
  output logic              refill_we,
  output logic [2:0]        refill_waddr
);

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT     = 2'd2,
    S_WAIT_INV = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tags_q [NWAYS];
  logic [7:0]         valid_q, valid_d;
  logic [6:0]         plru_q, plru_d;
  logic [TAG_W-1:0]   r_tag_q, r_tag_d;
  logic [2:0]         r_way_q, r_way_d;
  logic [2:0]         victim;
  logic [2:0]         hit_way;
  logic               do_write;

  // Point every node on way w's path away from w (node 0 root, 1..2 level 1, 3..6 level 2).
  function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] n;
    logic [2:0] i1;
    logic [2:0] i2;
    n     = p;
    i1    = {2'b00, w[2]} + 3'd1;
    i2    = {1'b0, w[2], w[1]} + 3'd3;
    n[0]  = ~w[2];
    n[i1] = ~w[1];
    n[i2] = ~w[0];
    return n;
  endfunction

  // Victim: lowest invalid way, else follow the PLRU tree from the root.
  always_comb begin
    logic       b0, b1, b2;
    logic [2:0] i2;
    b0 = plru_q[0];
    b1 = b0 ? plru_q[2] : plru_q[1];
    i2 = {1'b0, b0, b1} + 3'd3;
    b2 = plru_q[i2];
    victim = {b0, b1, b2};
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim = 3'(i);
    end
  end

  // Lowest-indexed hit way drives the PLRU update on a hit.
  always_comb begin
    hit_way = 3'd0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (hits[i]) hit_way = 3'(i);
    end
  end

  // Next-state and refill control; invalidate always beats a returning translation.
  always_comb begin
    state_d   = state_q;
    r_tag_d   = r_tag_q;
    r_way_d   = r_way_q;
    plru_d    = plru_q;
    do_write  = 1'b0;
    case (state_q)
      S_READY: begin
        if (io_req_valid && tlb_miss) begin
          r_tag_d = {io_ptw_ptbr_asid, io_req_bits_vpn};
          r_way_d = victim;
          state_d = S_REQUEST;
        end else if (io_req_valid && (|hits)) begin
          plru_d = plru_touch(plru_q, hit_way);
        end
      end
      S_REQUEST: begin
        if (io_ptw_req_ready) begin
          state_d = io_ptw_invalidate ? S_WAIT_INV : S_WAIT;
        end else if (io_ptw_invalidate) begin
          state_d = S_READY;
        end
      end
      S_WAIT: begin
        if (io_ptw_resp_valid) begin
          state_d = S_READY;
          if (!io_ptw_resp_bits_error && !io_ptw_invalidate) begin
            do_write = 1'b1;
            plru_d   = plru_touch(plru_q, r_way_q);
          end
        end else if (io_ptw_invalidate) begin
          state_d = S_WAIT_INV;
        end
      end
      S_WAIT_INV: begin
        if (io_ptw_resp_valid) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // Valid bits: refill sets the victim's bit, a flush clears everything.
  always_comb begin
    valid_d = valid_q;
    if (do_write) valid_d[r_way_q] = 1'b1;
    if (io_ptw_invalidate) valid_d = '0;
  end

  // State, capture registers, PLRU and tag array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_READY;
      valid_q <= '0;
      plru_q  <= 7'h0;
      r_tag_q <= '0;
      r_way_q <= 3'd0;
      for (int i = 0; i < NWAYS; i++) tags_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
      r_tag_q <= r_tag_d;
      r_way_q <= r_way_d;
      if (do_write) tags_q[r_way_q] <= r_tag_q;
    end
  end

  assign io_req_ready         = (state_q == S_READY);
  assign io_ptw_req_valid     = (state_q == S_REQUEST);
  assign io_ptw_req_bits_addr = r_tag_q[26:0];
  assign refill_we            = do_write;
  assign refill_waddr         = r_way_q;
  assign valid                = valid_q;
  assign tags_0 = tags_q[0];
  assign tags_1 = tags_q[1];
  assign tags_2 = tags_q[2];
  assign tags_3 = tags_q[3];
  assign tags_4 = tags_q[4];
  assign tags_5 = tags_q[5];
  assign tags_6 = tags_q[6];
  assign tags_7 = tags_q[7];

endmodule

// File: tb/tb_tlb_refill.sv
// tb/tb_tlb_refill.sv - self-checking bench for tlb_refill
module tb_tlb_refill;

  logic        clk;
  logic        reset_n;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [26:0] io_req_bits_vpn;
  logic [6:0]  io_ptw_ptbr_asid;
  logic        tlb_miss;
  logic [7:0]  hits;
  logic        io_ptw_req_valid;
  logic        io_ptw_req_ready;
  logic [26:0] io_ptw_req_bits_addr;
  logic        io_ptw_resp_valid;
  logic        io_ptw_resp_bits_error;
  logic        io_ptw_invalidate;
  logic [33:0] tags_0, tags_1, tags_2, tags_3, tags_4, tags_5, tags_6, tags_7;
  logic [7:0]  valid;
  logic        refill_we;
  logic [2:0]  refill_waddr;

  tlb_refill dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .io_req_valid           (io_req_valid),
    .io_req_ready           (io_req_ready),
    .io_req_bits_vpn        (io_req_bits_vpn),
    .io_ptw_ptbr_asid       (io_ptw_ptbr_asid),
    .tlb_miss               (tlb_miss),
    .hits                   (hits),
    .io_ptw_req_valid       (io_ptw_req_valid),
    .io_ptw_req_ready       (io_ptw_req_ready),
    .io_ptw_req_bits_addr   (io_ptw_req_bits_addr),
    .io_ptw_resp_valid      (io_ptw_resp_valid),
    .io_ptw_resp_bits_error (io_ptw_resp_bits_error),
    .io_ptw_invalidate      (io_ptw_invalidate),
    .tags_0                 (tags_0),
    .tags_1                 (tags_1),
    .tags_2                 (tags_2),
    .tags_3                 (tags_3),
    .tags_4                 (tags_4),
    .tags_5                 (tags_5),
    .tags_6                 (tags_6),
    .tags_7                 (tags_7),
    .valid                  (valid),
    .refill_we              (refill_we),
    .refill_waddr           (refill_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] vpn;
    logic [6:0]  asid;
    logic [2:0]  way;
  } vec_t;

  typedef struct {
    logic [2:0]  way;
    logic [33:0] tag;
  } sb_t;

  vec_t fill_tab [8];
  sb_t  sb_q [$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] tag_of(input logic [2:0] w);
    case (w)
      3'd0: return tags_0;
      3'd1: return tags_1;
      3'd2: return tags_2;
      3'd3: return tags_3;
      3'd4: return tags_4;
      3'd5: return tags_5;
      3'd6: return tags_6;
      default: return tags_7;
    endcase
  endfunction

  // Scoreboard monitor: each refill strobe pops the expected way/tag, contents checked one cycle on.
  logic        pend = 1'b0;
  logic [2:0]  pend_way;
  logic [33:0] pend_tag;
  always @(negedge clk) begin
    if (pend) begin
      chk("refill_tag", {30'h0, tag_of(pend_way)}, {30'h0, pend_tag});
      chk("refill_valid_bit", {63'h0, valid[pend_way]}, 64'h1);
      pend = 1'b0;
    end
    if (reset_n && refill_we) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_refill_we", {63'h0, refill_we}, 64'h0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("refill_waddr_sb", {61'h0, refill_waddr}, {61'h0, e.way});
        pend     = 1'b1;
        pend_way = e.way;
        pend_tag = e.tag;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    io_req_valid           = 1'b0;
    tlb_miss               = 1'b0;
    hits                   = 8'h00;
    io_ptw_req_ready       = 1'b0;
    io_ptw_resp_valid      = 1'b0;
    io_ptw_resp_bits_error = 1'b0;
    io_ptw_invalidate      = 1'b0;
  endtask

  // Full miss/walk/response sequence; called just after a rising edge while in S_READY.
  task automatic do_miss(input logic [26:0] vpn, input logic [6:0] asid,
                         input logic err, input logic [2:0] exp_way);
    sb_t e;
    io_req_valid     = 1'b1;
    tlb_miss         = 1'b1;
    io_req_bits_vpn  = vpn;
    io_ptw_ptbr_asid = asid;
    if (!err) begin
      e.way = exp_way;
      e.tag = {asid, vpn};
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("req_ready_idle", {63'h0, io_req_ready}, 64'h1);
    step();
    io_req_valid     = 1'b0;
    tlb_miss         = 1'b0;
    io_ptw_req_ready = 1'b1;
    @(negedge clk);
    chk("ptw_req_valid", {63'h0, io_ptw_req_valid}, 64'h1);
    chk("ptw_req_addr", {37'h0, io_ptw_req_bits_addr}, {37'h0, vpn});
    chk("victim_way", {61'h0, refill_waddr}, {61'h0, exp_way});
    step();
    io_ptw_req_ready       = 1'b0;
    io_ptw_resp_valid      = 1'b1;
    io_ptw_resp_bits_error = err;
    @(negedge clk);
    chk("ptw_req_valid_wait", {63'h0, io_ptw_req_valid}, 64'h0);
    chk("refill_we_resp", {63'h0, refill_we}, {63'h0, ~err});
    step();
    io_ptw_resp_valid      = 1'b0;
    io_ptw_resp_bits_error = 1'b0;
    @(negedge clk);
    chk("req_ready_after", {63'h0, io_req_ready}, 64'h1);
  endtask

  initial begin
    fill_tab[0] = '{27'h0001234, 7'h05, 3'd0};
    fill_tab[1] = '{27'h0002000, 7'h05, 3'd1};
    fill_tab[2] = '{27'h7FFFFFF, 7'h7F, 3'd2};
    fill_tab[3] = '{27'h0000000, 7'h00, 3'd3};
    fill_tab[4] = '{27'h5555555, 7'h2A, 3'd4};
    fill_tab[5] = '{27'h2AAAAAA, 7'h55, 3'd5};
    fill_tab[6] = '{27'h0ABCDEF, 7'h11, 3'd6};
    fill_tab[7] = '{27'h1000001, 7'h40, 3'd7};

    reset_n          = 1'b0;
    io_req_bits_vpn  = '0;
    io_ptw_ptbr_asid = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {56'h0, valid}, 64'h0);
    chk("rst_req_ready", {63'h0, io_req_ready}, 64'h1);
    chk("rst_ptw_req_valid", {63'h0, io_ptw_req_valid}, 64'h0);
    chk("rst_refill_we", {63'h0, refill_we}, 64'h0);
    chk("rst_tags_0", {30'h0, tags_0}, 64'h0);
    step();
    reset_n = 1'b1;

    // First refill and sequential fill of every way.
    for (int i = 0; i < 8; i++) begin
      step();
      do_miss(fill_tab[i].vpn, fill_tab[i].asid, 1'b0, fill_tab[i].way);
      if (i == 0) chk("first_valid", {56'h0, valid}, 64'h01);
    end
    chk("tags_0_first", {30'h0, tags_0}, {30'h0, 7'h05, 27'h0001234});
    chk("full_valid", {56'h0, valid}, 64'hFF);

    // Hit on way 0 flips the root right, so the next victim is way 4.
    step();
    io_req_valid = 1'b1;
    hits         = 8'h01;
    step();
    clear_inputs();
    do_miss(27'h0333333, 7'h03, 1'b0, 3'd4);
    chk("valid_after_plru", {56'h0, valid}, 64'hFF);

    // Walk error: no write, valid unchanged (victim would be way 2).
    step();
    do_miss(27'h0444444, 7'h04, 1'b1, 3'd2);
    chk("valid_after_err", {56'h0, valid}, 64'hFF);

    // Invalidate in S_WAIT, response three cycles later.
    step();
    io_req_valid     = 1'b1;
    tlb_miss         = 1'b1;
    io_req_bits_vpn  = 27'h0666666;
    io_ptw_ptbr_asid = 7'h06;
    step();
    clear_inputs();
    io_ptw_req_ready = 1'b1;
    step();
    io_ptw_req_ready  = 1'b0;
    io_ptw_invalidate = 1'b1;
    @(negedge clk);
    chk("inv_wait_refill_we", {63'h0, refill_we}, 64'h0);
    step();
    io_ptw_invalidate = 1'b0;
    @(negedge clk);
    chk("inv_valid_cleared", {56'h0, valid}, 64'h0);
    chk("inv_req_ready", {63'h0, io_req_ready}, 64'h0);
    step();
    step();
    io_ptw_resp_valid = 1'b1;
    @(negedge clk);
    chk("inv_resp_no_write", {63'h0, refill_we}, 64'h0);
    step();
    io_ptw_resp_valid = 1'b0;
    @(negedge clk);
    chk("inv_back_ready", {63'h0, io_req_ready}, 64'h1);
    chk("inv_valid_still0", {56'h0, valid}, 64'h0);

    // Refill way 0, then a miss with simultaneous flush that is dropped in S_REQUEST.
    step();
    do_miss(27'h0777777, 7'h07, 1'b0, 3'd0);
    chk("valid_way0", {56'h0, valid}, 64'h01);
    step();
    io_req_valid      = 1'b1;
    tlb_miss          = 1'b1;
    io_req_bits_vpn   = 27'h0888888;
    io_ptw_ptbr_asid  = 7'h08;
    io_ptw_invalidate = 1'b1;
    step();
    clear_inputs();
    io_ptw_invalidate = 1'b1;
    @(negedge clk);
    chk("miss_inv_valid", {56'h0, valid}, 64'h0);
    chk("miss_inv_captured", {63'h0, io_ptw_req_valid}, 64'h1);
    chk("miss_inv_addr", {37'h0, io_ptw_req_bits_addr}, {37'h0, 27'h0888888});
    chk("miss_inv_way", {61'h0, refill_waddr}, 64'h1);
    step();
    io_ptw_invalidate = 1'b0;
    @(negedge clk);
    chk("drop_req_ready", {63'h0, io_req_ready}, 64'h1);
    chk("drop_ptw_valid", {63'h0, io_ptw_req_valid}, 64'h0);

    // Accepted request with flush goes to S_WAIT_INV; the response is discarded.
    step();
    io_req_valid = 1'b1;
    tlb_miss     = 1'b1;
    step();
    clear_inputs();
    io_ptw_req_ready  = 1'b1;
    io_ptw_invalidate = 1'b1;
    step();
    clear_inputs();
    @(negedge clk);
    chk("waitinv_busy", {63'h0, io_req_ready}, 64'h0);
    step();
    io_ptw_resp_valid = 1'b1;
    @(negedge clk);
    chk("waitinv_no_write", {63'h0, refill_we}, 64'h0);
    step();
    clear_inputs();
    @(negedge clk);
    chk("waitinv_ready", {63'h0, io_req_ready}, 64'h1);
    chk("waitinv_valid", {56'h0, valid}, 64'h0);

    // Asynchronous reset in the middle of S_WAIT.
    step();
    do_miss(27'h0999999, 7'h09, 1'b0, 3'd0);
    step();
    io_req_valid     = 1'b1;
    tlb_miss         = 1'b1;
    io_req_bits_vpn  = 27'h0AAAAAA;
    io_ptw_ptbr_asid = 7'h0A;
    step();
    clear_inputs();
    io_ptw_req_ready = 1'b1;
    step();
    clear_inputs();
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_req_ready", {63'h0, io_req_ready}, 64'h1);
    chk("arst_valid", {56'h0, valid}, 64'h0);
    chk("arst_ptw_valid", {63'h0, io_ptw_req_valid}, 64'h0);
    chk("arst_tags_0", {30'h0, tags_0}, 64'h0);
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    chk("sb_empty", {32'h0, 32'(sb_q.size())}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
